// File: rtl/i2s_rx.sv
// -----------------------------------------------------------------------------
// i2s_rx : slave-mode I2S receiver.
//
// BCK, LRCK and DATA arrive from an external codec, asynchronous to clk_sys.
// Each input is brought in through a 2-FF synchronizer; a third BCK flop gives
// a rising-edge strobe (bck_rise) on which LRCK and DATA are sampled. Standard
// I2S framing is assumed: the data bit sampled together with an LRCK change is
// still the LSB of the outgoing word, and the next bit is the MSB of the new
// word. Words are left-aligned into DATA_WIDTH bits (short words zero-padded,
// extra bits dropped).
//
// Optional feature macro: I2S_RX_TAPE_EN
//   defined     : a hysteresis comparator slices the left channel into tape_bit.
//   not defined : no comparator, tape_bit is tied low.
// -----------------------------------------------------------------------------
module i2s_rx #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned TIMEOUT    = 1024,
  parameter logic [15:0] TAPE_HYST  = 16'd1024
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  i2s_bck,
  input  logic                  i2s_lrck,
  input  logic                  i2s_data,
  output logic [DATA_WIDTH-1:0] left_chan,
  output logic [DATA_WIDTH-1:0] right_chan,
  output logic                  sample_valid,
  output logic                  locked,
  output logic                  tape_bit
);

  // Bit-position counter saturates at DATA_WIDTH; insertion index addresses
  // one bit of the DATA_WIDTH-wide word.
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
  localparam int unsigned IDX_W = $clog2(DATA_WIDTH);
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_HUNT  = 2'd0;
  localparam logic [1:0] ST_LEFT  = 2'd1;
  localparam logic [1:0] ST_RIGHT = 2'd2;

  // ---------------------------------------------------------------------------
  // Input capture
  // ---------------------------------------------------------------------------
  logic bck_s1_q, bck_s2_q, bck_s3_q;
  logic lrck_s1_q, lrck_s2_q;
  logic data_s1_q, data_s2_q;

  // Two-stage synchronizers on all pins plus one BCK history flop.
  // NOTE: sequential state always uses <= so every flop samples the value from
  // before the edge; with = the chain would collapse into a single stage.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      bck_s1_q  <= 1'b0;
      bck_s2_q  <= 1'b0;
      bck_s3_q  <= 1'b0;
      lrck_s1_q <= 1'b0;
      lrck_s2_q <= 1'b0;
      data_s1_q <= 1'b0;
      data_s2_q <= 1'b0;
    end else begin
      bck_s1_q  <= i2s_bck;
      bck_s2_q  <= bck_s1_q;
      bck_s3_q  <= bck_s2_q;
      lrck_s1_q <= i2s_lrck;
      lrck_s2_q <= lrck_s1_q;
      data_s1_q <= i2s_data;
      data_s2_q <= data_s1_q;
    end
  end

  logic bck_rise;
  assign bck_rise = bck_s2_q & ~bck_s3_q;

  // ---------------------------------------------------------------------------
  // LRCK edge detection (in the BCK sample domain)
  // ---------------------------------------------------------------------------
  logic lrck_prev_q;
  logic lrck_fall;
  logic lrck_rise;
  logic lrck_edge;

  // Remember LRCK as seen at the previous BCK rising edge.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      lrck_prev_q <= 1'b0;
    end else if (bck_rise) begin
      lrck_prev_q <= lrck_s2_q;
    end
  end

  assign lrck_fall = bck_rise &  lrck_prev_q & ~lrck_s2_q;
  assign lrck_rise = bck_rise & ~lrck_prev_q &  lrck_s2_q;
  assign lrck_edge = lrck_fall | lrck_rise;

  // ---------------------------------------------------------------------------
  // Watchdog: counts clk_sys cycles since the last bck_rise
  // ---------------------------------------------------------------------------
  logic [WD_W-1:0] wd_q;
  logic            timeout_hit;

  // Restart on every BCK edge, otherwise count up and saturate at TIMEOUT.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wd_q <= '0;
    end else if (bck_rise) begin
      wd_q <= '0;
    end else if (wd_q != WD_W'(TIMEOUT)) begin
      wd_q <= wd_q + WD_W'(1);
    end
  end

  // Fires on the cycle whose closing edge is the TIMEOUT-th without a BCK edge.
  assign timeout_hit = ~bck_rise & (wd_q == WD_W'(TIMEOUT - 1));

  // ---------------------------------------------------------------------------
  // Word assembly
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      ins_idx;
  logic [DATA_WIDTH-1:0] word_ins;

  // Bit number cnt lands at position DATA_WIDTH-1-cnt (MSB first).
  assign ins_idx = IDX_W'(DATA_WIDTH - 1) - cnt_q[IDX_W-1:0];

  // Current word with the bit presently on DATA inserted; bits past
  // DATA_WIDTH are dropped, unfilled LSBs stay zero.
  // NOTE: every always_comb output gets a default on entry so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    word_ins = shift_q;
    if (cnt_q < CNT_W'(DATA_WIDTH)) begin
      word_ins[ins_idx] = data_s2_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Framing state machine
  // ---------------------------------------------------------------------------
  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] left_q, left_d;
  logic [DATA_WIDTH-1:0] right_q, right_d;
  logic                  valid_q, valid_d;
  logic                  locked_q, locked_d;

  // Next-state logic: word boundaries, channel latching and lock tracking.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    left_d   = left_q;
    right_d  = right_q;
    valid_d  = 1'b0;
    locked_d = locked_q;

    if (timeout_hit) begin
      // Stream lost: resynchronise, keep the last samples on the outputs.
      state_d  = ST_HUNT;
      locked_d = 1'b0;
    end else if (bck_rise) begin
      if (lrck_edge) begin
        // The bit with the LRCK change closes the old word; start a new one.
        shift_d = '0;
        cnt_d   = '0;
      end else begin
        shift_d = word_ins;
        if (cnt_q < CNT_W'(DATA_WIDTH)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      case (state_q)
        ST_HUNT: begin
          if (lrck_fall) begin
            state_d = ST_LEFT;
          end
        end
        ST_LEFT: begin
          if (lrck_rise) begin
            hold_d  = word_ins;
            state_d = ST_RIGHT;
          end
        end
        ST_RIGHT: begin
          if (lrck_fall) begin
            right_d  = word_ins;
            left_d   = hold_q;
            valid_d  = 1'b1;
            locked_d = 1'b1;
            state_d  = ST_LEFT;
          end
        end
        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end
  end

  // State and datapath registers; reset discards any partial word.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_HUNT;
      shift_q  <= '0;
      cnt_q    <= '0;
      hold_q   <= '0;
      left_q   <= '0;
      right_q  <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      left_q   <= left_d;
      right_q  <= right_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
    end
  end

  assign left_chan    = left_q;
  assign right_chan   = right_q;
  assign sample_valid = valid_q;
  assign locked       = locked_q;

  // ---------------------------------------------------------------------------
  // Tape level slicer
  // ---------------------------------------------------------------------------
`ifdef I2S_RX_TAPE_EN
  localparam logic signed [DATA_WIDTH-1:0] HYST_POS = DATA_WIDTH'(TAPE_HYST);
  localparam logic signed [DATA_WIDTH-1:0] HYST_NEG = -HYST_POS;

  logic tape_q;

  // Compare the freshly published left sample; hold inside the dead band,
  // force low whenever the stream is not locked.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tape_q <= 1'b0;
    end else if (!locked_q) begin
      tape_q <= 1'b0;
    end else if (valid_q) begin
      if ($signed(left_q) > HYST_POS) begin
        tape_q <= 1'b1;
      end else if ($signed(left_q) < HYST_NEG) begin
        tape_q <= 1'b0;
      end
    end
  end

  assign tape_bit = tape_q;
`else
  assign tape_bit = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// -----------------------------------------------------------------------------
// tb_i2s_rx : directed bench for i2s_rx.
// A behavioural codec drives standard I2S (LRCK and DATA change on BCK fall,
// one-bit delay). A monitor records every sample_valid pulse; the main process
// compares the recorded samples against hand-computed values.
// Honours I2S_RX_TAPE_EN for the tape_bit expectations.
// -----------------------------------------------------------------------------
module tb_i2s_rx;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        i2s_bck = 1'b0;
  logic        i2s_lrck = 1'b0;
  logic        i2s_data = 1'b0;
  logic [15:0] left_chan;
  logic [15:0] right_chan;
  logic        sample_valid;
  logic        locked;
  logic        tape_bit;

  i2s_rx dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .i2s_bck      (i2s_bck),
    .i2s_lrck     (i2s_lrck),
    .i2s_data     (i2s_data),
    .left_chan    (left_chan),
    .right_chan   (right_chan),
    .sample_valid (sample_valid),
    .locked       (locked),
    .tape_bit     (tape_bit)
  );

  // clk_sys: period 10, rising edges at 5 + 10k.
  always #5 clk_sys = ~clk_sys;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Pulse monitor
  // ---------------------------------------------------------------------------
  logic [15:0] q_left[$];
  logic [15:0] q_right[$];
  logic        q_tape[$];
  int          run_len = 0;
  int          max_run = 0;
  bit          tape_due = 1'b0;

  always @(negedge clk_sys) begin
    if (tape_due) begin
      q_tape.push_back(tape_bit);
      tape_due = 1'b0;
    end
    if (sample_valid === 1'b1) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      q_left.push_back(left_chan);
      q_right.push_back(right_chan);
      tape_due = 1'b1;
    end else begin
      run_len = 0;
    end
  end

  task automatic clear_q();
    q_left.delete();
    q_right.delete();
    q_tape.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Codec model
  // ---------------------------------------------------------------------------
  logic last_bit     = 1'b0;
  bit   tail_pending = 1'b0;
  time  t_last_rise  = 0;

  // Stimulus transitions sit 2 time units after a multiple of 10, away from
  // every clk_sys edge.
  task automatic align();
    @(posedge clk_sys);
    #7;
  endtask

  // One channel of n BCK slots: slot 0 carries the previous word's LSB, the
  // remaining slots carry word[n-1] down to word[1].
  task automatic send_word(input logic lr, input logic [31:0] word, input int n, input int half);
    for (int i = 0; i < n; i++) begin
      if (!(i == 0 && tail_pending && lr == 1'b0)) begin
        i2s_bck  = 1'b0;
        i2s_lrck = lr;
        i2s_data = (i == 0) ? last_bit : word[n-i];
        #(half);
        i2s_bck     = 1'b1;
        t_last_rise = $time;
        #(half);
      end
    end
    tail_pending = 1'b0;
    last_bit     = word[0];
  endtask

  // Closing slot: LRCK back low, carrying the last right-word LSB.
  task automatic send_tail(input int half);
    i2s_bck  = 1'b0;
    i2s_lrck = 1'b0;
    i2s_data = last_bit;
    #(half);
    i2s_bck     = 1'b1;
    t_last_rise = $time;
    #(half);
    tail_pending = 1'b1;
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int half);
    send_word(1'b0, {l, 16'h0000}, 32, half);
    send_word(1'b1, {r, 16'h0000}, 32, half);
  endtask

  localparam int HALF_SLOW = 50;  // BCK = clk_sys / 10
  localparam int HALF_FAST = 20;  // BCK = clk_sys / 4

  logic [15:0] tape_left[6] = '{16'h0000, 16'h07D0, 16'h01F4, 16'hFE0C, 16'hF830, 16'hFE0C};
`ifdef I2S_RX_TAPE_EN
  logic        tape_exp[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
`else
  logic        tape_exp[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
  logic [15:0] exp_l[100];
  logic [15:0] exp_r[100];
  logic [15:0] hold_l;
  logic [15:0] hold_r;
  logic [15:0] sl_l[4] = '{16'hABC0, 16'hABC0, 16'h1234, 16'h1234};
  logic [15:0] sl_r[4] = '{16'h1230, 16'h1230, 16'hFEDC, 16'hFEDC};

  initial begin
    // ---- reset state ----
    #22;
    check("rst_left",   32'(left_chan),    32'h0);
    check("rst_right",  32'(right_chan),   32'h0);
    check("rst_valid",  32'(sample_valid), 32'h0);
    check("rst_locked", 32'(locked),       32'h0);
    check("rst_tape",   32'(tape_bit),     32'h0);
    reset_n = 1'b1;

    // ---- basic frames: first frame has no leading LRCK fall ----
    align();
    clear_q();
    for (int f = 0; f < 3; f++) send_frame(16'h8001, 16'h7FFE, HALF_SLOW);
    send_tail(HALF_SLOW);
    #100;
    check("basic_count", 32'(q_left.size()), 32'd2);
    for (int k = 0; k < 2 && k < q_left.size(); k++) begin
      check($sformatf("basic_left%0d", k),  32'(q_left[k]),  32'h8001);
      check($sformatf("basic_right%0d", k), 32'(q_right[k]), 32'h7FFE);
    end
    check("basic_pulse_width", 32'(max_run), 32'd1);
    check("basic_locked", 32'(locked), 32'h1);

    // ---- short (12-bit) then long (24-bit) words ----
    align();
    clear_q();
    for (int f = 0; f < 2; f++) begin
      send_word(1'b0, 32'h0000_0ABC, 12, HALF_SLOW);
      send_word(1'b1, 32'h0000_0123, 12, HALF_SLOW);
    end
    for (int f = 0; f < 2; f++) begin
      send_word(1'b0, 32'h0012_3456, 24, HALF_SLOW);
      send_word(1'b1, 32'h00FE_DCBA, 24, HALF_SLOW);
    end
    send_tail(HALF_SLOW);
    #100;
    check("width_count", 32'(q_left.size()), 32'd4);
    for (int k = 0; k < 4 && k < q_left.size(); k++) begin
      check($sformatf("width_left%0d", k),  32'(q_left[k]),  32'(sl_l[k]));
      check($sformatf("width_right%0d", k), 32'(q_right[k]), 32'(sl_r[k]));
    end

    // ---- timeout: BCK stops after the tail slot ----
    // Last pin rise at t_r is acted on at t_r+23; lock drops 1024 cycles later
    // at t_r+23+10240. Sample on the negedges either side of that edge.
    hold_l = 16'h1234;
    hold_r = 16'hFEDC;
    #(t_last_rise + 64'd10258 - $time);
    check("timeout_locked_before", 32'(locked), 32'h1);
    #10;
    check("timeout_locked_after", 32'(locked), 32'h0);
    check("timeout_hold_left",  32'(left_chan),  32'(hold_l));
    check("timeout_hold_right", 32'(right_chan), 32'(hold_r));

    // ---- restart: only the second full frame is emitted ----
    align();
    clear_q();
    send_frame(16'h1111, 16'h2222, HALF_SLOW);
    send_frame(16'h3333, 16'h4444, HALF_SLOW);
    send_tail(HALF_SLOW);
    #100;
    check("restart_count", 32'(q_left.size()), 32'd1);
    if (q_left.size() > 0) begin
      check("restart_left",  32'(q_left[0]),  32'h3333);
      check("restart_right", 32'(q_right[0]), 32'h4444);
    end
    check("restart_locked", 32'(locked), 32'h1);

    // ---- asynchronous reset in the middle of a right word ----
    align();
    clear_q();
    send_word(1'b0, {16'hDEAD, 16'h0000}, 32, HALF_SLOW);
    send_word(1'b1, {16'hBEEF, 16'h0000}, 12, HALF_SLOW);
    check("prereset_locked", 32'(locked), 32'h1);
    #5;
    reset_n = 1'b0;
    #1;
    check("midrst_left",   32'(left_chan),    32'h0);
    check("midrst_right",  32'(right_chan),   32'h0);
    check("midrst_valid",  32'(sample_valid), 32'h0);
    check("midrst_locked", 32'(locked),       32'h0);
    check("midrst_tape",   32'(tape_bit),     32'h0);
    #14;
    reset_n = 1'b1;
    send_word(1'b1, {16'hBEEF, 16'h0000}, 20, HALF_SLOW);
    send_frame(16'h0100, 16'h5A5A, HALF_SLOW);
    send_tail(HALF_SLOW);
    #100;
    check("postrst_count", 32'(q_left.size()), 32'd1);
    if (q_left.size() > 0) begin
      check("postrst_left",  32'(q_left[0]),  32'h0100);
      check("postrst_right", 32'(q_right[0]), 32'h5A5A);
    end

    // ---- tape comparator sequence ----
    align();
    clear_q();
    for (int f = 0; f < 6; f++) send_frame(tape_left[f], 16'h5A5A, HALF_SLOW);
    send_tail(HALF_SLOW);
    #100;
    check("tape_count", 32'(q_tape.size()), 32'd6);
    for (int k = 0; k < 6 && k < q_tape.size(); k++) begin
      check($sformatf("tape_left%0d", k), 32'(q_left[k]), 32'(tape_left[k]));
      check($sformatf("tape_bit%0d", k),  32'(q_tape[k]), 32'(tape_exp[k]));
    end

    // ---- maximum BCK rate, random words ----
    for (int f = 0; f < 100; f++) begin
      exp_l[f] = 16'($urandom);
      exp_r[f] = 16'($urandom);
    end
    align();
    clear_q();
    for (int f = 0; f < 100; f++) send_frame(exp_l[f], exp_r[f], HALF_FAST);
    send_tail(HALF_FAST);
    #100;
    check("fast_count", 32'(q_left.size()), 32'd100);
    for (int k = 0; k < 100 && k < q_left.size(); k++) begin
      check($sformatf("fast_left%0d", k),  32'(q_left[k]),  32'(exp_l[k]));
      check($sformatf("fast_right%0d", k), 32'(q_right[k]), 32'(exp_r[k]));
    end
    check("pulse_width_all", 32'(max_run), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
